// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the ALU-side divider.
//   DIV_W       : operand / result width
//   CNT_W       : iteration counter width (holds 0..DIV_W)
//   div_state_t : divider FSM state encoding
package alu_pkg;

    localparam int DIV_W = 32;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_ITER = 2'd2,
        S_FIX  = 2'd3
    } div_state_t;

    // Two's-complement magnitude select: take the negated copy when the
    // operand is signed and its MSB is set.
    function automatic logic [DIV_W-1:0] pick_abs(
        input logic             is_signed,
        input logic [DIV_W-1:0] raw,
        input logic [DIV_W-1:0] negated
    );
        return (is_signed && raw[DIV_W-1]) ? negated : raw;
    endfunction

endpackage

// File: rtl/div_sub_stage.sv
// cla_add8
//   8-bit carry-look-ahead adder block.
//   a, b : addends
//   cin  : carry in
//   sum  : a + b + cin (low 8 bits)
//   cout : carry out
module cla_add8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [7:0] p;
    logic [7:0] g;
    logic [8:0] c;

    always_comb begin
        p    = a ^ b;
        g    = a & b;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        sum  = p ^ c[7:0];
        cout = c[8];
    end

endmodule

// div_sub_stage
//   (W+1)-bit subtract/compare: diff = a - b, computed as a + ~b + 1 over a
//   chain of 8-bit CLA blocks. Operands are zero-extended to a whole number
//   of blocks, so the final carry is the unsigned "a >= b" flag.
//   a, b   : W+1-bit unsigned operands
//   diff   : a - b truncated to W+1 bits
//   borrow : 1 when a < b (unsigned)
module div_sub_stage #(
    parameter int W = 32
) (
    input  logic [W:0] a,
    input  logic [W:0] b,
    output logic [W:0] diff,
    output logic       borrow
);

    localparam int NB = (W + 8) / 8;
    localparam int P  = NB * 8;

    logic [P-1:0] a_pad;
    logic [P-1:0] nb_pad;
    logic [P-1:0] sum_pad;

    always_comb begin
        a_pad         = '0;
        a_pad[W:0]    = a;
        // Upper pad bits of ~b are ones because b is zero-extended.
        nb_pad        = '1;
        nb_pad[W:0]   = ~b;
    end

    for (genvar i = 0; i < NB; i++) begin : blk
        logic ci;
        logic co;
        if (i == 0) begin : g_first
            assign ci = 1'b1;
        end else begin : g_chain
            assign ci = blk[i-1].co;
        end
        cla_add8 u_cla (
            .a    (a_pad[8*i +: 8]),
            .b    (nb_pad[8*i +: 8]),
            .cin  (ci),
            .sum  (sum_pad[8*i +: 8]),
            .cout (co)
        );
    end

    assign diff   = sum_pad[W:0];
    assign borrow = ~blk[NB-1].co;

    logic unused_pad;
    assign unused_pad = ^sum_pad;

endmodule

// File: rtl/seq_divider_32b.sv
// seq_divider_32b
//   Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU.
//   One trial subtraction per ITER cycle; W iterations per operation.
//   CLK    : rising-edge clock
//   RST_N  : asynchronous active-low reset
//   START  : request, sampled only while BUSY=0
//   SIGNED : 1 = signed, 0 = unsigned; sampled with START
//   A, B   : dividend / divisor; sampled with START
//   BUSY   : high from the cycle after an accepted START through DONE
//   DONE   : one-cycle pulse, results valid
//   Q, R   : quotient / remainder, held until the next DONE
//   DIV0   : divisor was zero for the last completed operation
//
//   state  | meaning
//   IDLE   | waiting for START (or presenting DONE with BUSY still high)
//   PREP   | take magnitudes, record result signs, seed shift registers
//   ITER   | one shift / trial-subtract / restore step per cycle
//   FIX    | apply signs or divide-by-zero values, raise DONE
module seq_divider_32b
    import alu_pkg::*;
#(
    parameter int W     = DIV_W,
    parameter int CNT_W = alu_pkg::CNT_W
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         START,
    input  logic         SIGNED,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         BUSY,
    output logic         DONE,
    output logic [W-1:0] Q,
    output logic [W-1:0] R,
    output logic         DIV0
);

    div_state_t state;

    logic [W-1:0]     a_lat;
    logic [W-1:0]     b_lat;
    logic             sgn_lat;
    logic [W-1:0]     abs_b;
    logic [W:0]       rem;
    logic [W-1:0]     quo;
    logic [CNT_W-1:0] cnt;
    logic             neg_q;
    logic             neg_r;
    logic             div0_flag;

    logic [W:0] rem_sh;
    logic [W:0] main_a;
    logic [W:0] main_b;
    logic [W:0] main_diff;
    logic       main_borrow;
    logic [W:0] neg_b;
    logic [W:0] neg_diff;
    logic       neg_borrow;

    assign rem_sh = {rem[W-1:0], quo[W-1]};

    // The main stage does the trial subtraction in ITER; it is otherwise idle,
    // so PREP uses it to negate B and FIX uses it to negate the quotient.
    // The second stage always computes 0 - x: A in PREP, remainder in FIX.
    always_comb begin
        main_a = '0;
        main_b = '0;
        neg_b  = '0;
        case (state)
            S_PREP: begin
                main_b = {1'b0, b_lat};
                neg_b  = {1'b0, a_lat};
            end
            S_ITER: begin
                main_a = rem_sh;
                main_b = {1'b0, abs_b};
            end
            S_FIX: begin
                main_b = {1'b0, quo};
                neg_b  = {1'b0, rem[W-1:0]};
            end
            default: begin
                main_a = '0;
            end
        endcase
    end

    div_sub_stage #(.W(W)) u_trial (
        .a      (main_a),
        .b      (main_b),
        .diff   (main_diff),
        .borrow (main_borrow)
    );

    div_sub_stage #(.W(W)) u_negate (
        .a      ('0),
        .b      (neg_b),
        .diff   (neg_diff),
        .borrow (neg_borrow)
    );

    logic unused_bits;
    assign unused_bits = ^{main_diff[W], neg_diff[W], neg_borrow};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= S_IDLE;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            Q         <= '0;
            R         <= '0;
            DIV0      <= 1'b0;
            a_lat     <= '0;
            b_lat     <= '0;
            sgn_lat   <= 1'b0;
            abs_b     <= '0;
            rem       <= '0;
            quo       <= '0;
            cnt       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            div0_flag <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    // BUSY is still high in the DONE cycle, which blocks a
                    // START presented alongside DONE.
                    if (START && !BUSY) begin
                        a_lat   <= A;
                        b_lat   <= B;
                        sgn_lat <= SIGNED;
                        BUSY    <= 1'b1;
                        state   <= S_PREP;
                    end else begin
                        BUSY <= 1'b0;
                    end
                end
                S_PREP: begin
                    quo       <= pick_abs(sgn_lat, a_lat, neg_diff[W-1:0]);
                    abs_b     <= pick_abs(sgn_lat, b_lat, main_diff[W-1:0]);
                    neg_q     <= sgn_lat & (a_lat[W-1] ^ b_lat[W-1]);
                    neg_r     <= sgn_lat & a_lat[W-1];
                    rem       <= '0;
                    cnt       <= '0;
                    div0_flag <= (b_lat == '0);
                    state     <= (b_lat == '0) ? S_FIX : S_ITER;
                end
                S_ITER: begin
                    if (!main_borrow) begin
                        rem <= main_diff;
                        quo <= {quo[W-2:0], 1'b1};
                    end else begin
                        rem <= rem_sh;
                        quo <= {quo[W-2:0], 1'b0};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(W - 1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (div0_flag) begin
                        Q <= '1;
                        R <= a_lat;
                    end else begin
                        Q <= neg_q ? main_diff[W-1:0] : quo;
                        R <= neg_r ? neg_diff[W-1:0] : rem[W-1:0];
                    end
                    DIV0  <= div0_flag;
                    DONE  <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_32b.sv
// tb_seq_divider_32b
//   Directed vector table, hand-written multi-cycle sequences (START while
//   busy, reset mid-operation) and a back-to-back random run against a
//   behavioural division model.
module tb_seq_divider_32b;

    logic        CLK;
    logic        RST_N;
    logic        START;
    logic        SIGNED;
    logic [31:0] A;
    logic [31:0] B;
    logic        BUSY;
    logic        DONE;
    logic [31:0] Q;
    logic [31:0] R;
    logic        DIV0;

    int total = 0;
    int bad   = 0;

    seq_divider_32b dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .START  (START),
        .SIGNED (SIGNED),
        .A      (A),
        .B      (B),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .Q      (Q),
        .R      (R),
        .DIV0   (DIV0)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        d0;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%h required=0x%h", name, act, exp);
        end
    endtask

    task automatic model(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
        longint sa;
        longint sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // Called at #1 after a posedge with BUSY=0. Returns at #1 after the
    // edge that ends the DONE cycle; START is held high across DONE with
    // junk operands to confirm it is ignored there.
    task automatic do_op(input string tag, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eq,
                         input logic [31:0] er, input logic ed0);
        int lat;
        START  = 1'b1;
        SIGNED = s;
        A      = a;
        B      = b;
        @(posedge CLK);
        #1;
        START  = 1'b0;
        SIGNED = ~s;
        A      = ~a;
        B      = $urandom;
        chk({tag, " busy_after_start"}, 32'(BUSY), 32'd1);
        lat = 0;
        do begin
            @(posedge CLK);
            #1;
            lat++;
        end while (!DONE && lat < 60);
        if (!DONE) begin
            chk({tag, " done_timeout"}, 32'(lat), (b == 32'd0) ? 32'd2 : 32'd34);
            return;
        end
        chk({tag, " latency"}, 32'(lat), (b == 32'd0) ? 32'd2 : 32'd34);
        chk({tag, " q"}, Q, eq);
        chk({tag, " r"}, R, er);
        chk({tag, " div0"}, 32'(DIV0), 32'(ed0));
        chk({tag, " busy_in_done"}, 32'(BUSY), 32'd1);
        START = 1'b1;
        A     = 32'd9;
        B     = 32'd3;
        @(posedge CLK);
        #1;
        START = 1'b0;
        chk({tag, " done_pulse"}, 32'(DONE), 32'd0);
        chk({tag, " busy_released"}, 32'(BUSY), 32'd0);
        chk({tag, " q_hold"}, Q, eq);
    endtask

    vec_t vecs[12];

    initial begin
        logic [31:0] eq;
        logic [31:0] er;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        int          n;

        vecs[0]  = '{1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
        vecs[1]  = '{1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
        vecs[2]  = '{1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         1'b0};
        vecs[3]  = '{1'b0, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,         1'b1};
        vecs[4]  = '{1'b1, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,         1'b1};
        vecs[5]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0};
        vecs[6]  = '{1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0};
        vecs[7]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0};
        vecs[8]  = '{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        32'hFFFF_FFFE, 1'b0};
        vecs[9]  = '{1'b0, 32'd0,         32'd3,         32'd0,         32'd0,         1'b0};
        vecs[10] = '{1'b0, 32'h8000_0000, 32'd3,         32'h2AAA_AAAA, 32'd2,         1'b0};
        vecs[11] = '{1'b1, 32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1};

        RST_N  = 1'b0;
        START  = 1'b0;
        SIGNED = 1'b0;
        A      = '0;
        B      = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset busy", 32'(BUSY), 32'd0);
        chk("reset done", 32'(DONE), 32'd0);
        chk("reset q", Q, 32'd0);
        chk("reset r", R, 32'd0);
        chk("reset div0", 32'(DIV0), 32'd0);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        for (int i = 0; i < 12; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b,
                  vecs[i].q, vecs[i].r, vecs[i].d0);
        end

        // START pulsed again at k+10 with other operands must not disturb
        // the operation in flight.
        begin
            int lat;
            START  = 1'b1;
            SIGNED = 1'b0;
            A      = 32'd1000;
            B      = 32'd10;
            @(posedge CLK);
            #1;
            START = 1'b0;
            repeat (9) @(posedge CLK);
            #1;
            START  = 1'b1;
            SIGNED = 1'b1;
            A      = 32'd7;
            B      = 32'd1;
            @(posedge CLK);
            #1;
            START = 1'b0;
            lat = 10;
            while (!DONE && lat < 60) begin
                @(posedge CLK);
                #1;
                lat++;
            end
            chk("busy_restart latency", 32'(lat), 32'd34);
            chk("busy_restart q", Q, 32'd100);
            chk("busy_restart r", R, 32'd0);
            @(posedge CLK);
            #1;
            chk("busy_restart idle", 32'(BUSY), 32'd0);
        end

        // Reset in the middle of an operation.
        START  = 1'b1;
        SIGNED = 1'b0;
        A      = 32'd50;
        B      = 32'd5;
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (15) @(posedge CLK);
        #1;
        RST_N = 1'b0;
        #1;
        chk("midreset busy", 32'(BUSY), 32'd0);
        chk("midreset done", 32'(DONE), 32'd0);
        chk("midreset q", Q, 32'd0);
        chk("midreset r", R, 32'd0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        chk("postreset busy", 32'(BUSY), 32'd0);
        do_op("postreset", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

        // Back-to-back random operations at the earliest accept.
        n = 1000;
        for (int i = 0; i < n; i++) begin
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'd1;
                2:       rb = 32'hFFFF_FFFF;
                3:       rb = 32'($urandom_range(2, 20));
                default: rb = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0:       ra = 32'($urandom_range(0, 100));
                1:       ra = 32'h8000_0000;
                default: ra = $urandom;
            endcase
            model(rs, ra, rb, eq, er);
            do_op($sformatf("rnd%0d", i), rs, ra, rb, eq, er, rb == 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
